// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// rtl/bsg_fifo_rolly_replay_ctrl.sv - go-back-N replay controller sitting behind a rolly 1r1w FIFO
module bsg_fifo_rolly_replay_ctrl #(
  parameter int width_p       = 8,
  parameter int lg_size_p     = 2,
  parameter int timeout_p     = 64,
  parameter int max_retries_p = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [width_p-1:0]   fifo_data_i,
  input  logic                 fifo_v_i,
  output logic                 fifo_yumi_o,
  output logic                 fifo_deq_v_o,
  output logic                 fifo_roll_v_o,
  output logic [width_p-1:0]   data_o,
  output logic                 v_o,
  input  logic                 ready_i,
  input  logic                 ack_v_i,
  input  logic                 nack_v_i,
  input  logic                 clr_i,
  output logic [lg_size_p:0]   outstanding_o,
  output logic                 fail_o,
  output logic                 proto_err_o
);

  localparam int CW = lg_size_p + 1;
  localparam int TW = $clog2(timeout_p + 1);
  localparam int RW = $clog2(max_retries_p + 1);

  localparam logic [CW-1:0] DEPTH   = CW'(1 << lg_size_p);
  // Compare against the pre-increment value so the replay fires as the timer reaches timeout_p-1.
  localparam logic [TW-1:0] TO_LAST = TW'((timeout_p >= 2) ? timeout_p - 2 : 0);
  localparam logic [RW-1:0] MAX_R   = RW'(max_retries_p);

  typedef enum logic [1:0] {S_SEND, S_ROLL, S_FAIL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retries_q, retries_d;
  logic            fail_q, fail_d;
  logic            perr_q, perr_d;

  logic            v, yumi, deq, roll;
  logic            has_out, timeout;
  logic [RW-1:0]   retry_base;

  assign has_out = (outst_q != '0);

  always_comb begin
    state_d    = state_q;
    outst_d    = outst_q;
    timer_d    = timer_q;
    retries_d  = retries_q;
    fail_d     = fail_q;
    perr_d     = perr_q;
    v          = 1'b0;
    yumi       = 1'b0;
    deq        = 1'b0;
    roll       = 1'b0;
    timeout    = 1'b0;
    retry_base = retries_q;

    case (state_q)
      S_SEND: begin
        // Gated by reset so the link sees nothing while the FIFO itself is still resetting.
        v    = reset_n_i & fifo_v_i & (outst_q < DEPTH);
        yumi = v & ready_i;
        if (ack_v_i) begin
          if (has_out) deq    = 1'b1;
          else         perr_d = 1'b1;
        end
        outst_d = outst_q + CW'(yumi) - CW'(deq);
        timeout = has_out & ~deq & (timer_q == TO_LAST);
        timer_d = (!has_out || deq) ? '0 : timer_q + TW'(1);
        if (has_out && (nack_v_i || timeout)) begin
          retry_base = deq ? '0 : retries_q;
          timer_d    = '0;
          if (retry_base == MAX_R) begin
            state_d   = S_FAIL;
            fail_d    = 1'b1;
            retries_d = retry_base;
          end else begin
            state_d   = S_ROLL;
            retries_d = retry_base + RW'(1);
          end
        end else if (deq) begin
          retries_d = '0;
        end
      end

      S_ROLL: begin
        roll    = 1'b1;
        outst_d = '0;
        timer_d = '0;
        state_d = S_SEND;
        if (ack_v_i || nack_v_i) perr_d = 1'b1;
      end

      S_FAIL: begin
        timer_d = '0;
        if (ack_v_i) begin
          if (has_out) begin
            deq     = 1'b1;
            outst_d = outst_q - CW'(1);
          end else begin
            perr_d = 1'b1;
          end
        end
        if (clr_i) begin
          state_d   = S_ROLL;
          retries_d = '0;
          fail_d    = 1'b0;
          perr_d    = 1'b0;
        end
      end

      default: state_d = S_SEND;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_SEND;
      outst_q   <= '0;
      timer_q   <= '0;
      retries_q <= '0;
      fail_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      fail_q    <= fail_d;
      perr_q    <= perr_d;
    end
  end

  assign data_o        = fifo_data_i;
  assign v_o           = v;
  assign fifo_yumi_o   = yumi;
  assign fifo_deq_v_o  = deq;
  assign fifo_roll_v_o = roll;
  assign outstanding_o = outst_q;
  assign fail_o        = fail_q;
  assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// tb/tb_bsg_fifo_rolly_replay_ctrl.sv - directed bench with a behavioural rolly FIFO in front of the controller
module tb_bsg_fifo_rolly_replay_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] fifo_data;
  logic       fifo_v;
  logic       yumi, deq, roll;
  logic [7:0] data_o;
  logic       v_o;
  logic       ready, ack_v, nack_v, clr_v;
  logic [2:0] outst;
  logic       fail, perr;

  logic [7:0] mem [16];
  logic [3:0] wptr, rptr, cptr;
  int         yumi_cnt = 0, deq_cnt = 0, roll_cnt = 0;
  int         total = 0, bad = 0;
  int         y0, d0, r0;

  always #5 clk = ~clk;

  bsg_fifo_rolly_replay_ctrl #(
    .width_p(8), .lg_size_p(2), .timeout_p(8), .max_retries_p(3)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .fifo_data_i(fifo_data), .fifo_v_i(fifo_v),
    .fifo_yumi_o(yumi), .fifo_deq_v_o(deq), .fifo_roll_v_o(roll),
    .data_o(data_o), .v_o(v_o), .ready_i(ready),
    .ack_v_i(ack_v), .nack_v_i(nack_v), .clr_i(clr_v),
    .outstanding_o(outst), .fail_o(fail), .proto_err_o(perr)
  );

  // Rolly FIFO model: speculative read pointer, committed pointer, roll rewinds.
  assign fifo_v    = (rptr != wptr);
  assign fifo_data = mem[rptr];

  always @(posedge clk) begin
    if (!reset_n) begin
      rptr <= '0;
      cptr <= '0;
    end else begin
      if (roll)      rptr <= cptr;
      else if (yumi) rptr <= rptr + 4'd1;
      if (deq)       cptr <= cptr + 4'd1;
      if (yumi) yumi_cnt <= yumi_cnt + 1;
      if (deq)  deq_cnt  <= deq_cnt + 1;
      if (roll) roll_cnt <= roll_cnt + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic ack, input logic nack, input logic clr);
    @(negedge clk);
    ready  = rdy;
    ack_v  = ack;
    nack_v = nack;
    clr_v  = clr;
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    ready     = 1'b0;
    mem[wptr] = d;
    wptr      = wptr + 4'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ready = 1'b0; ack_v = 1'b0; nack_v = 1'b0; clr_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wptr    = '0;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    ready = 1'b0; ack_v = 1'b0; nack_v = 1'b0; clr_v = 1'b0;
    wptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    do_reset();
    #1;
    check("rst_v", v_o, 0);
    check("rst_yumi", yumi, 0);
    check("rst_deq", deq, 0);
    check("rst_roll", roll, 0);
    check("rst_outst", outst, 0);
    check("rst_fail", fail, 0);
    check("rst_perr", perr, 0);

    // basic stream
    push(8'h10); push(8'h11); push(8'h12);
    d0 = deq_cnt; r0 = roll_cnt;
    step(1, 0, 0, 0); check("b1_yumi", yumi, 1); check("b1_data", data_o, 8'h10); check("b1_out", outst, 0);
    step(1, 0, 0, 0); check("b2_yumi", yumi, 1); check("b2_data", data_o, 8'h11); check("b2_out", outst, 1);
    step(1, 0, 0, 0); check("b3_yumi", yumi, 1); check("b3_data", data_o, 8'h12); check("b3_out", outst, 2);
    step(1, 1, 0, 0); check("b4_v", v_o, 0); check("b4_deq", deq, 1); check("b4_out", outst, 3);
    step(1, 1, 0, 0); check("b5_deq", deq, 1); check("b5_out", outst, 2);
    step(1, 1, 0, 0); check("b6_deq", deq, 1); check("b6_out", outst, 1);
    step(1, 0, 0, 0); check("b7_out", outst, 0);
    check("b_deqs", deq_cnt - d0, 3);
    check("b_rolls", roll_cnt - r0, 0);

    // window full
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    y0 = yumi_cnt;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      check("w_yumi", yumi, 1);
      check("w_data", data_o, 8'h20 + i);
    end
    step(1, 0, 0, 0); check("w5_v", v_o, 0); check("w5_out", outst, 4);
    step(1, 0, 0, 0); check("w6_v", v_o, 0); check("w6_out", outst, 4);
    check("w_yumis", yumi_cnt - y0, 4);
    step(1, 1, 0, 0); check("w7_deq", deq, 1); check("w7_v", v_o, 0);
    step(1, 0, 0, 0); check("w8_out", outst, 3); check("w8_yumi", yumi, 1); check("w8_data", data_o, 8'h24);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0); check("w_drain_out", outst, 0); check("w_perr", perr, 0);

    // nack replay
    push(8'h30); push(8'h31); push(8'h32);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("n_data", data_o, 8'h30 + i);
    end
    step(1, 1, 0, 0); check("n_ackA_deq", deq, 1);
    step(1, 0, 1, 0); check("n_nack_roll", roll, 0); check("n_nack_deq", deq, 0);
    step(1, 0, 0, 0); check("n_roll", roll, 1); check("n_roll_v", v_o, 0); check("n_roll_yumi", yumi, 0);
    step(1, 0, 0, 0); check("n_after_out", outst, 0); check("n_resendB", data_o, 8'h31); check("n_resendB_y", yumi, 1);
    step(1, 0, 0, 0); check("n_resendC", data_o, 8'h32); check("n_resendC_y", yumi, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0); check("n_end_out", outst, 0);

    // timeout replay
    push(8'h40);
    step(1, 0, 0, 0); check("t_send", data_o, 8'h40); check("t_send_y", yumi, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0);
      check("t_noroll", roll, 0);
    end
    step(1, 0, 0, 0); check("t_roll", roll, 1);
    step(1, 0, 0, 0); check("t_resend", data_o, 8'h40); check("t_resend_y", yumi, 1);
    step(1, 1, 0, 0); check("t_ack_deq", deq, 1);
    step(0, 0, 0, 0); check("t_end_out", outst, 0);

    // retry exhaustion
    push(8'h50);
    step(1, 0, 0, 0); check("x_send", yumi, 1);
    r0 = roll_cnt;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0); check("x_nack_roll", roll, 0);
      if (i < 3) begin
        step(1, 0, 0, 0); check("x_roll", roll, 1);
        step(1, 0, 0, 0); check("x_resend", data_o, 8'h50); check("x_resend_y", yumi, 1);
      end
    end
    step(1, 0, 1, 0); check("x_fail", fail, 1); check("x_fail_v", v_o, 0); check("x_fail_roll", roll, 0);
    check("x_rolls", roll_cnt - r0, 3);
    step(1, 0, 0, 0); check("x_fail_v2", v_o, 0); check("x_fail_out", outst, 1);
    step(1, 0, 0, 1); check("x_clr_fail", fail, 1);
    step(1, 0, 0, 0); check("x_clr_roll", roll, 1); check("x_clr_failoff", fail, 0); check("x_clr_v", v_o, 0);
    step(1, 0, 0, 0); check("x_resume_y", yumi, 1); check("x_resume_d", data_o, 8'h50);
    step(1, 1, 0, 0); check("x_resume_deq", deq, 1);
    step(0, 0, 0, 0); check("x_end_out", outst, 0); check("x_end_perr", perr, 0);

    // protocol errors
    step(0, 1, 0, 0); check("p_ack0_deq", deq, 0);
    step(0, 0, 0, 0); check("p_ack0_perr", perr, 1);
    do_reset();
    #1;
    check("p_rst_perr", perr, 0);
    push(8'h60);
    step(1, 0, 0, 0); check("p_send", yumi, 1);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0); check("p_roll", roll, 1); check("p_roll_deq", deq, 0);
    step(1, 0, 0, 0); check("p_roll_perr", perr, 1); check("p_resend", data_o, 8'h60); check("p_out", outst, 0);
    step(1, 1, 0, 0); check("p_ack_deq", deq, 1);
    push(8'h70); push(8'h71); push(8'h72);
    step(1, 0, 0, 0); check("m_y70", data_o, 8'h70);
    step(1, 0, 0, 0); check("m_v71", v_o, 1);
    #1 reset_n = 1'b0;
    #1;
    check("m_rst_v", v_o, 0);
    check("m_rst_yumi", yumi, 0);
    check("m_rst_deq", deq, 0);
    check("m_rst_roll", roll, 0);
    check("m_rst_out", outst, 0);
    check("m_rst_fail", fail, 0);
    check("m_rst_perr", perr, 0);
    @(negedge clk);
    wptr    = '0;
    ready   = 1'b0;
    reset_n = 1'b1;
    #1;
    check("m_post_out", outst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_rolly_replay_ctrl.md
Name: bsg_fifo_rolly_replay_ctrl

Overview:
- Sits directly downstream of the rolly 1r1w FIFO and drives its yumi, deq and roll inputs.
- Forwards FIFO entries to a ready/valid link speculatively and keeps every sent-but-unacknowledged entry in the FIFO.
- An in-order ack commits the oldest outstanding entry.
- A nack or timeout rolls the FIFO read pointer back so all uncommitted entries are resent; a bounded retry count escalates to a sticky failure.

Parameters:
- width_p, (required), data width; matches the FIFO.
- lg_size_p, (required), log2 of FIFO depth; the outstanding window is 2^lg_size_p.
- timeout_p, 64, cycles without an ack while entries are outstanding before an automatic replay.
- max_retries_p, 3, consecutive replays without an ack before entering FAIL.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- fifo_data_i  in  width_p  FIFO data_o (combinational read at the read pointer).
- fifo_v_i  in  1  FIFO v_o.
- fifo_yumi_o  out  1  speculative read to the FIFO (advances the read pointer).
- fifo_deq_v_o  out  1  commits the oldest entry in the FIFO.
- fifo_roll_v_o  out  1  rewinds the FIFO read pointer to the committed pointer.
- data_o  out  width_p  link data; equals fifo_data_i.
- v_o  out  1  link valid.
- ready_i  in  1  link ready.
- ack_v_i  in  1  oldest outstanding entry delivered.
- nack_v_i  in  1  request a replay of all outstanding entries.
- clr_i  in  1  clear FAIL state.
- outstanding_o  out  lg_size_p+1  sent-but-uncommitted count.
- fail_o  out  1  sticky retry-exhaustion flag.
- proto_err_o  out  1  sticky protocol-violation flag.

Behaviour:
- States are SEND, ROLL and FAIL. Reset (reset_n_i low, asynchronous) gives:
  - state=SEND;
  - outstanding=0, timer=0, retries=0;
  - fail_o=0, proto_err_o=0;
  - all outputs other than data_o are 0.
- SEND:
  - v_o = fifo_v_i & (outstanding < 2^lg_size_p).
  - fifo_yumi_o = v_o & ready_i.
  - data_o is passed through combinationally, with zero latency.
- ROLL and FAIL: v_o=0 and fifo_yumi_o=0.
- Ack handling (SEND only):
  - ack_v_i with outstanding>0 gives fifo_deq_v_o=1 in the same cycle, outstanding-1, timer=0, retries=0.
  - ack_v_i with outstanding==0 is ignored and sets proto_err_o.
- Outstanding update in one cycle: next = outstanding + yumi - deq. A simultaneous yumi and ack leaves the count unchanged.
- Timer (SEND only):
  - Increments when outstanding>0 and no ack is seen that cycle.
  - Held at 0 when outstanding==0.
  - Reaching timeout_p-1 with no ack raises an internal replay request, exactly as a nack does.
- Replay request in SEND (nack_v_i or timeout):
  - If retries==max_retries_p: go to FAIL and set fail_o.
  - Otherwise: retries+1, go to ROLL.
  - An ack in the same cycle as the request is still committed that cycle (deq first, roll later).
  - A replay request with outstanding==0 is a no-op, with no ROLL and no retry increment.
- ROLL lasts exactly one cycle:
  - fifo_roll_v_o=1; outstanding, timer ← 0; next state SEND.
  - Any ack_v_i or nack_v_i during ROLL is dropped and sets proto_err_o.
- FAIL:
  - Holds fail_o=1. Acks are still committed; nacks are ignored.
  - clr_i moves to ROLL with retries=0 and clears fail_o and proto_err_o.
- Never assert fifo_yumi_o in the same cycle as fifo_roll_v_o. Never assert fifo_deq_v_o in the same cycle as fifo_roll_v_o.
- Width rules:
  - outstanding saturates logically at 2^lg_size_p via the v_o gate; there is no wrap.
  - The timer is $clog2(timeout_p+1) bits; retries is $clog2(max_retries_p+1) bits.
- Reset asserted mid-transfer returns everything to reset values immediately. The FIFO pointers are reset by the FIFO's own reset.

Test Plan:
- Basic stream: lg_size_p=2, ready_i=1, push 3 entries, ack each 2 cycles later → yumi on 3 consecutive cycles; outstanding 1,2,3 then falls to 0; 3 deq pulses; no roll.
- Window full: push 6 entries with no acks → exactly 4 yumis; v_o=0 with outstanding_o=4; one ack → the 5th entry is sent the following cycle.
- Nack replay: send A,B,C, ack A, then nack → deq for A; one-cycle roll; outstanding_o=0; then B and C are resent in order on data_o.
- Timeout: timeout_p=8, send 1 entry, withhold ack → roll asserted 8 cycles after the send and the entry is resent; an ack then clears the retry count.
- Retry exhaustion: max_retries_p=3, nack 4 times with no ack → 3 rolls, then fail_o=1 and v_o stuck at 0; clr_i → one roll cycle, fail_o=0, resend resumes.
- Protocol errors: ack with outstanding=0, and an ack during the ROLL cycle → proto_err_o=1 and no deq issued; async reset mid-stream → all outputs 0 immediately.
